// File: rtl/spi_reg_ctrl_if.sv
// Bus between the SPI byte slave / display path and the register controller.
// The controller takes the slave modport; the environment driving frames takes master.
interface spi_reg_ctrl_if;
    logic        cs_n;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;
    logic        tx_load;
    logic [15:0] display_value;
    logic        display_en;
    logic [7:0]  err_count;

    modport slave (
        input  cs_n, rx_valid, rx_byte,
        output tx_byte, tx_load, display_value, display_en, err_count
    );

    modport master (
        output cs_n, rx_valid, rx_byte,
        input  tx_byte, tx_load, display_value, display_en, err_count
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI frame parser and four-entry register file feeding the seven-segment display.
// Frames are cmd+data (write) or cmd+dummy (read); bad or aborted frames bump err_count.
module spi_reg_ctrl (
    input  logic            clk,
    input  logic            rst,
    spi_reg_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WDATA = 3'd2,
        ST_RDATA = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] ID_VALUE = 8'hA5;

    state_t      state_r, state_s;
    logic        cs_n_prev_r;
    logic [1:0]  addr_r, addr_s;
    logic [7:0]  disp_lo_r, disp_hi_r;
    logic        ctrl_en_r;
    logic [7:0]  tx_byte_r, tx_byte_s;
    logic        tx_load_r, tx_load_s;
    logic [7:0]  err_r;
    logic        err_inc_s;
    logic        wr_en_s;
    logic        cmd_ok_s;

    function automatic logic [7:0] reg_read(input logic [1:0] addr, input logic [7:0] lo,
                                            input logic [7:0] hi, input logic en);
        logic [7:0] val;
        case (addr)
            2'd0:    val = lo;
            2'd1:    val = hi;
            2'd2:    val = {7'd0, en};
            2'd3:    val = ID_VALUE;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

    // Next-state, readback and write/error strobes for the frame parser.
    always_comb begin
        state_s   = state_r;
        addr_s    = addr_r;
        tx_byte_s = tx_byte_r;
        tx_load_s = 1'b0;
        err_inc_s = 1'b0;
        wr_en_s   = 1'b0;
        cmd_ok_s  = (bus.rx_byte[6:2] == 5'd0);
        case (state_r)
            // Only a fresh falling edge of cs_n opens a frame, so a frame cut by reset is skipped.
            ST_IDLE: begin
                if (!bus.cs_n && cs_n_prev_r) begin
                    state_s = ST_CMD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (bus.rx_valid) begin
                    if (!cmd_ok_s) begin
                        err_inc_s = 1'b1;
                        state_s   = ST_DONE;
                    end else if (bus.rx_byte[7]) begin
                        addr_s  = bus.rx_byte[1:0];
                        state_s = ST_WDATA;
                    end else begin
                        tx_byte_s = reg_read(bus.rx_byte[1:0], disp_lo_r, disp_hi_r, ctrl_en_r);
                        tx_load_s = 1'b1;
                        state_s   = ST_RDATA;
                    end
                end else begin
                    state_s = ST_CMD;
                end
            end
            ST_WDATA: begin
                if (bus.rx_valid) begin
                    if (addr_r == 2'd3) begin
                        err_inc_s = 1'b1;
                    end else begin
                        wr_en_s = 1'b1;
                    end
                    state_s = ST_DONE;
                end else if (bus.cs_n) begin
                    err_inc_s = 1'b1;
                end else begin
                    state_s = ST_WDATA;
                end
            end
            ST_RDATA: begin
                if (bus.rx_valid || bus.cs_n) begin
                    tx_byte_s = 8'h00;
                    tx_load_s = ~tx_load_r;
                    state_s   = ST_DONE;
                end else begin
                    state_s = ST_RDATA;
                end
            end
            ST_DONE: begin
                state_s = ST_DONE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        if (bus.cs_n && (state_r != ST_IDLE)) begin
            state_s = ST_IDLE;
        end else begin
            state_s = state_s;
        end
    end

    // State, register file, readback and saturating error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cs_n_prev_r <= 1'b0;
            addr_r      <= 2'd0;
            disp_lo_r   <= 8'h00;
            disp_hi_r   <= 8'h00;
            ctrl_en_r   <= 1'b1;
            tx_byte_r   <= 8'h00;
            tx_load_r   <= 1'b0;
            err_r       <= 8'h00;
        end else begin
            state_r     <= state_s;
            cs_n_prev_r <= bus.cs_n;
            addr_r      <= addr_s;
            tx_byte_r   <= tx_byte_s;
            tx_load_r   <= tx_load_s;
            if (err_inc_s && (err_r != 8'hFF)) begin
                err_r <= err_r + 8'd1;
            end
            if (wr_en_s) begin
                case (addr_r)
                    2'd0:    disp_lo_r <= bus.rx_byte;
                    2'd1:    disp_hi_r <= bus.rx_byte;
                    2'd2:    ctrl_en_r <= bus.rx_byte[0];
                    default: ctrl_en_r <= ctrl_en_r;
                endcase
            end
        end
    end

    assign bus.tx_byte       = tx_byte_r;
    assign bus.tx_load       = tx_load_r;
    assign bus.display_value = {disp_hi_r, disp_lo_r};
    assign bus.display_en    = ctrl_en_r;
    assign bus.err_count     = err_r;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: drivers queue expected values with a target cycle,
// a negedge monitor compares them and every tx_load pulse against the readback queue.
module tb_spi_reg_ctrl;
    localparam int K_DISP = 0;
    localparam int K_EN   = 1;
    localparam int K_ERR  = 2;
    localparam int K_TXB  = 3;
    localparam int K_TXLD = 4;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t chk_q[$];
    exp_t tx_q[$];

    spi_reg_ctrl_if bus();

    spi_reg_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] actual(input int kind);
        case (kind)
            K_DISP:  return bus.display_value;
            K_EN:    return {15'd0, bus.display_en};
            K_ERR:   return {8'd0, bus.err_count};
            K_TXB:   return {8'd0, bus.tx_byte};
            default: return {15'd0, bus.tx_load};
        endcase
    endfunction

    function automatic string kname(input int kind);
        case (kind)
            K_DISP:  return "display_value";
            K_EN:    return "display_en";
            K_ERR:   return "err_count";
            K_TXB:   return "tx_byte";
            default: return "tx_load";
        endcase
    endfunction

    // Monitor: readback pulses and cycle-targeted status checks.
    always @(negedge clk) begin
        if (bus.tx_load === 1'b1) begin
            checks++;
            if (tx_q.size() == 0) begin
                failures++;
                $display("FAIL tx_load_unexpected cyc=%0d tx_byte=%h", cyc, bus.tx_byte);
            end else begin
                exp_t e;
                e = tx_q.pop_front();
                if (bus.tx_byte !== e.val[7:0] || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL readback cyc=%0d actual=%h required=%h at cyc %0d",
                             cyc, bus.tx_byte, e.val[7:0], e.cyc);
                end
            end
        end
        for (int i = chk_q.size() - 1; i >= 0; i--) begin
            if (chk_q[i].cyc == cyc) begin
                logic [15:0] a;
                a = actual(chk_q[i].kind);
                checks++;
                if (a !== chk_q[i].val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d actual=%h required=%h",
                             kname(chk_q[i].kind), cyc, a, chk_q[i].val);
                end
                chk_q.delete(i);
            end
        end
    end

    task automatic expect_at(input int at, input int kind, input logic [15:0] v);
        exp_t e;
        e.cyc = at; e.kind = kind; e.val = v;
        chk_q.push_back(e);
    endtask

    task automatic check_now(input int kind, input logic [15:0] v);
        expect_at(cyc, kind, v);
    endtask

    task automatic expect_tx(input int at, input logic [7:0] v);
        exp_t e;
        e.cyc = at; e.kind = K_TXB; e.val = {8'd0, v};
        tx_q.push_back(e);
    endtask

    task automatic cs_low();
        @(posedge clk); #1;
        bus.cs_n = 1'b0;
    endtask

    task automatic cs_high();
        @(posedge clk); #1;
        bus.cs_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    // Write frame; checks the target output is unchanged in the data cycle and updated one edge later.
    task automatic write_frame(input logic [7:0] cmd, input logic [7:0] data, input int kind,
                               input logic [15:0] old_v, input logic [15:0] new_v);
        cs_low();
        drive_byte(cmd);
        @(posedge clk); #1;
        bus.rx_valid = 1'b1;
        bus.rx_byte  = data;
        expect_at(cyc, kind, old_v);
        expect_at(cyc + 1, kind, new_v);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        cs_high();
    endtask

    task automatic read_frame(input logic [7:0] cmd, input logic [7:0] exp_v);
        cs_low();
        @(posedge clk); #1;
        bus.rx_valid = 1'b1;
        bus.rx_byte  = cmd;
        expect_tx(cyc + 1, exp_v);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        @(posedge clk); #1;
        bus.rx_valid = 1'b1;
        bus.rx_byte  = 8'h00;
        expect_tx(cyc + 1, 8'h00);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        cs_high();
        check_now(K_TXB, 16'h0000);
    endtask

    initial begin
        bus.cs_n     = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_now(K_DISP, 16'h0000);
        check_now(K_EN,   16'h0001);
        check_now(K_ERR,  16'h0000);
        check_now(K_TXB,  16'h0000);
        check_now(K_TXLD, 16'h0000);

        write_frame(8'h80, 8'h3C, K_DISP, 16'h0000, 16'h003C);
        write_frame(8'h81, 8'h12, K_DISP, 16'h003C, 16'h123C);
        write_frame(8'h82, 8'h00, K_EN,   16'h0001, 16'h0000);

        read_frame(8'h03, 8'hA5);
        read_frame(8'h01, 8'h12);
        read_frame(8'h02, 8'h00);

        // Invalid command with trailing bytes.
        cs_low();
        drive_byte(8'h84);
        drive_byte(8'h55);
        drive_byte(8'h66);
        cs_high();
        check_now(K_ERR,  16'h0001);
        check_now(K_DISP, 16'h123C);
        check_now(K_EN,   16'h0000);

        // Write to the read-only ID register.
        cs_low();
        drive_byte(8'h83);
        drive_byte(8'h11);
        cs_high();
        check_now(K_ERR, 16'h0002);
        read_frame(8'h03, 8'hA5);

        // Abort after a write command.
        cs_low();
        drive_byte(8'h80);
        cs_high();
        check_now(K_ERR,  16'h0003);
        check_now(K_DISP, 16'h123C);

        // Data byte coincident with cs_n rising.
        cs_low();
        drive_byte(8'h80);
        @(posedge clk); #1;
        bus.rx_valid = 1'b1;
        bus.rx_byte  = 8'h77;
        bus.cs_n     = 1'b1;
        expect_at(cyc, K_DISP, 16'h123C);
        expect_at(cyc + 1, K_DISP, 16'h1277);
        expect_at(cyc + 2, K_ERR, 16'h0003);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        @(posedge clk); #1;

        write_frame(8'h82, 8'hFF, K_EN, 16'h0000, 16'h0001);
        read_frame(8'h02, 8'h01);
        read_frame(8'h00, 8'h77);

        // Saturation of the error counter.
        for (int i = 0; i < 300; i++) begin
            cs_low();
            drive_byte(8'hFC);
            cs_high();
            if (i == 250) check_now(K_ERR, 16'h00FE);
        end
        check_now(K_ERR, 16'h00FF);

        // Reset in the middle of a write frame.
        cs_low();
        drive_byte(8'h81);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_now(K_DISP, 16'h0000);
        check_now(K_EN,   16'h0001);
        check_now(K_ERR,  16'h0000);
        check_now(K_TXB,  16'h0000);
        drive_byte(8'h99);
        check_now(K_DISP, 16'h0000);
        check_now(K_ERR,  16'h0000);
        cs_high();
        write_frame(8'h81, 8'h42, K_DISP, 16'h0000, 16'h4200);
        read_frame(8'h01, 8'h42);

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (chk_q.size() != 0) begin
            failures++;
            $display("FAIL pending_checks actual=%0d required=0", chk_q.size());
        end
        checks++;
        if (tx_q.size() != 0) begin
            failures++;
            $display("FAIL missing_tx_load actual=%0d pending required=0", tx_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
